// File: rtl/glm_multi_dot.sv
// glm_multi_dot: streams sample lines against NUM_MODELS model lines and emits one dot product per model per sample.
// Define GLM_MULTI_DOT_BIAS_EN to add cfg_bias, which is subtracted per model when a result is loaded.
module glm_multi_dot #(
  parameter int VALUES_PER_LINE = 16,
  parameter int VALUE_W         = 32,
  parameter int NUM_MODELS      = 4,
  parameter int ACC_W           = 64,
  parameter int CNT_W           = 16,
  localparam int CH_W           = (NUM_MODELS > 1) ? $clog2(NUM_MODELS) : 1
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         op_start,
  output logic                                         op_done,
  input  logic [CNT_W-1:0]                             cfg_num_lines,
  input  logic [CNT_W-1:0]                             cfg_num_samples,
  input  logic [CNT_W-1:0]                             cfg_model_offset,
`ifdef GLM_MULTI_DOT_BIAS_EN
  input  logic [NUM_MODELS*ACC_W-1:0]                  cfg_bias,
`endif
  input  logic                                         in_empty,
  output logic                                         in_re,
  input  logic                                         in_rvalid,
  input  logic [VALUES_PER_LINE*VALUE_W-1:0]           in_rdata,
  output logic                                         model_re,
  output logic [CNT_W-1:0]                             model_raddr,
  input  logic [NUM_MODELS*VALUES_PER_LINE*VALUE_W-1:0] model_rdata,
  input  logic                                         out_full,
  output logic                                         out_we,
  output logic [ACC_W-1:0]                             out_wdata,
  output logic [CH_W-1:0]                              out_channel,
  output logic                                         out_last
);

  localparam int PROD_W = 2 * VALUE_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0] iss_line_q, iss_line_d;
  logic [CNT_W-1:0] iss_samp_q, iss_samp_d;
  logic [CNT_W-1:0] rv_line_q, rv_line_d;
  logic [CNT_W-1:0] out_samp_q, out_samp_d;
  logic             inflight_q;
  logic             buf_valid_q, buf_valid_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [ACC_W-1:0] acc_q [NUM_MODELS];
  logic [ACC_W-1:0] acc_d [NUM_MODELS];
  logic [ACC_W-1:0] buf_q [NUM_MODELS];
  logic [ACC_W-1:0] buf_d [NUM_MODELS];
`ifdef GLM_MULTI_DOT_BIAS_EN
  logic [NUM_MODELS*ACC_W-1:0] bias_q, bias_d;
`endif

  logic signed [PROD_W-1:0] prod [NUM_MODELS][VALUES_PER_LINE];
  logic [ACC_W-1:0]         dot  [NUM_MODELS];

  logic issue, drain, first_line, all_issued, rv_last, ch_last, rv_run;

  always_comb begin
    for (int unsigned m = 0; m < NUM_MODELS; m++) begin
      for (int unsigned i = 0; i < VALUES_PER_LINE; i++) begin
        prod[m][i] = PROD_W'($signed(in_rdata[i*VALUE_W +: VALUE_W])) *
                     PROD_W'($signed(model_rdata[(m*VALUES_PER_LINE+i)*VALUE_W +: VALUE_W]));
      end
    end
  end

  always_comb begin
    for (int unsigned m = 0; m < NUM_MODELS; m++) begin
      dot[m] = '0;
      for (int unsigned i = 0; i < VALUES_PER_LINE; i++) begin
        dot[m] = dot[m] + ACC_W'(prod[m][i]);
      end
    end
  end

  // A sample's first line waits for the previous result to drain and its last line to land,
  // so the accumulators and the result buffer are never shared between two samples.
  assign first_line = (iss_line_q == '0);
  assign all_issued = (iss_samp_q == samples_q);
  assign issue      = (state_q == S_RUN) && !in_empty && !all_issued &&
                      (!first_line || (!buf_valid_q && !inflight_q));
  assign rv_run     = (state_q == S_RUN) && in_rvalid;
  assign rv_last    = (rv_line_q == lines_q - CNT_W'(1));
  assign drain      = buf_valid_q && !out_full;
  assign ch_last    = (ch_q == CH_W'(NUM_MODELS - 1));

  always_comb begin
    state_d     = state_q;
    lines_d     = lines_q;
    samples_d   = samples_q;
    offset_d    = offset_q;
    iss_line_d  = iss_line_q;
    iss_samp_d  = iss_samp_q;
    rv_line_d   = rv_line_q;
    out_samp_d  = out_samp_q;
    buf_valid_d = buf_valid_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    buf_d       = buf_q;
`ifdef GLM_MULTI_DOT_BIAS_EN
    bias_d      = bias_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (op_start) begin
          lines_d     = cfg_num_lines;
          samples_d   = cfg_num_samples;
          offset_d    = cfg_model_offset;
`ifdef GLM_MULTI_DOT_BIAS_EN
          bias_d      = cfg_bias;
`endif
          iss_line_d  = '0;
          iss_samp_d  = '0;
          rv_line_d   = '0;
          out_samp_d  = '0;
          ch_d        = '0;
          buf_valid_d = 1'b0;
          acc_d       = '{default: '0};
          state_d     = ((cfg_num_lines == '0) || (cfg_num_samples == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (iss_line_q == lines_q - CNT_W'(1)) begin
            iss_line_d = '0;
            iss_samp_d = iss_samp_q + CNT_W'(1);
          end else begin
            iss_line_d = iss_line_q + CNT_W'(1);
          end
        end
        if (rv_run) begin
          if (rv_last) begin
            rv_line_d   = '0;
            buf_valid_d = 1'b1;
            for (int unsigned m = 0; m < NUM_MODELS; m++) begin
`ifdef GLM_MULTI_DOT_BIAS_EN
              buf_d[m] = acc_q[m] + dot[m] - bias_q[m*ACC_W +: ACC_W];
`else
              buf_d[m] = acc_q[m] + dot[m];
`endif
              acc_d[m] = '0;
            end
          end else begin
            rv_line_d = rv_line_q + CNT_W'(1);
            for (int unsigned m = 0; m < NUM_MODELS; m++) begin
              acc_d[m] = acc_q[m] + dot[m];
            end
          end
        end
        if (drain) begin
          if (ch_last) begin
            ch_d        = '0;
            buf_valid_d = 1'b0;
            out_samp_d  = out_samp_q + CNT_W'(1);
            if (out_samp_q == samples_q - CNT_W'(1)) state_d = S_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lines_q     <= '0;
      samples_q   <= '0;
      offset_q    <= '0;
      iss_line_q  <= '0;
      iss_samp_q  <= '0;
      rv_line_q   <= '0;
      out_samp_q  <= '0;
      inflight_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      ch_q        <= '0;
      acc_q       <= '{default: '0};
      buf_q       <= '{default: '0};
`ifdef GLM_MULTI_DOT_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lines_q     <= lines_d;
      samples_q   <= samples_d;
      offset_q    <= offset_d;
      iss_line_q  <= iss_line_d;
      iss_samp_q  <= iss_samp_d;
      rv_line_q   <= rv_line_d;
      out_samp_q  <= out_samp_d;
      inflight_q  <= issue;
      buf_valid_q <= buf_valid_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
`ifdef GLM_MULTI_DOT_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end

  assign op_done     = (state_q == S_DONE);
  assign in_re       = issue;
  assign model_re    = issue;
  assign model_raddr = offset_q + iss_line_q;
  assign out_we      = drain;
  assign out_wdata   = buf_q[ch_q];
  assign out_channel = ch_q;
  assign out_last    = drain && ch_last;

endmodule
